// File: rtl/wide_shift_pkg.sv
// Shared types and constants for the 16-bit wide-shift sequencer.
package wide_shift_pkg;
  localparam int BYTE_W  = 8;
  localparam int AMT_W   = 4;
  localparam int LATENCY = 4;

  typedef enum logic [2:0] {
    IDLE,
    SH_A,
    SH_B,
    SH_C,
    DONE
  } state_t;
endpackage

// File: rtl/wide_shift_ctrl_shifter.sv
// 8-bit combinational logical shifter shared by the wide-shift sequencer.
module Shifter
  import wide_shift_pkg::*;
(
  input  logic [BYTE_W-1:0] operand,
  input  logic              direction,
  input  logic [2:0]        shiftAmount,
  output logic [BYTE_W-1:0] result
);

  assign result = direction ? (operand >> shiftAmount) : (operand << shiftAmount);

endmodule

// File: rtl/wide_shift_ctrl.sv
// 16-bit logical shift of {hi,lo} by 0..15, sequenced over three cycles
// through a single shared 8-bit Shifter.
module wide_shift_ctrl
  import wide_shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] opHi,
  input  logic [BYTE_W-1:0] opLo,
  input  logic              direction,
  input  logic [AMT_W-1:0]  amount,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] resHi,
  output logic [BYTE_W-1:0] resLo
);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                dir_q, dir_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic [BYTE_W-1:0]   carry_q, carry_d;
  logic [BYTE_W-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic [BYTE_W-1:0]   sh_op, sh_res;
  logic                sh_dir;
  logic [2:0]          sh_amt;
  logic                wide, zero_amt, accept;

  assign wide     = amt_q[3];
  assign zero_amt = (amt_q == '0);

  Shifter u_shifter (
    .operand     (sh_op),
    .direction   (sh_dir),
    .shiftAmount (sh_amt),
    .result      (sh_res)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dir_d    = dir_q;
    amt_d    = amt_q;
    carry_d  = carry_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    sh_op    = '0;
    sh_dir   = dir_q;
    sh_amt   = amt_q[2:0];
    accept   = 1'b0;

    case (state_q)
      IDLE: accept = start;
      SH_A: begin
        state_d = SH_B;
        sh_op   = dir_q ? hi_q : lo_q;
        if (dir_q) res_hi_d = wide ? '0 : sh_res;
        else       res_lo_d = wide ? '0 : sh_res;
      end
      SH_B: begin
        state_d = SH_C;
        sh_op   = dir_q ? hi_q : lo_q;
        if (wide) begin
          if (dir_q) res_lo_d = sh_res;
          else       res_hi_d = sh_res;
        end else begin
          // Bits crossing the byte boundary: opposite direction by 8-n, which is -n mod 8.
          sh_dir  = ~dir_q;
          sh_amt  = 3'd0 - amt_q[2:0];
          carry_d = zero_amt ? '0 : sh_res;
        end
      end
      SH_C: begin
        state_d = DONE;
        sh_op   = dir_q ? lo_q : hi_q;
        if (!wide) begin
          if (dir_q) res_lo_d = sh_res | carry_q;
          else       res_hi_d = sh_res | carry_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = SH_A;
      hi_d     = opHi;
      lo_d     = opLo;
      dir_d    = direction;
      amt_d    = amount;
      carry_d  = '0;
      res_hi_d = '0;
      res_lo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      dir_q    <= 1'b0;
      amt_q    <= '0;
      carry_q  <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dir_q    <= dir_d;
      amt_q    <= amt_d;
      carry_q  <= carry_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy  = (state_q == SH_A) || (state_q == SH_B) || (state_q == SH_C);
  assign done  = (state_q == DONE);
  assign resHi = res_hi_q;
  assign resLo = res_lo_q;

endmodule
